// File: rtl/expu_pkg.sv
// rtl/expu_pkg.sv - shared types and width helpers for the softmax denominator accumulator
package expu_pkg;

  typedef enum logic [1:0] {
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_e;

  function automatic int exp_bias(input int exponent_bits);
    return (1 << (exponent_bits - 1)) - 1;
  endfunction

  function automatic int float_width(input int mantissa_bits, input int exponent_bits);
    return mantissa_bits + exponent_bits + 1;
  endfunction

endpackage

// File: rtl/expu_fp2fix.sv
// rtl/expu_fp2fix.sv - combinational float to unsigned fixed-point conversion with overflow flag
module expu_fp2fix
  import expu_pkg::*;
#(
  parameter int MANTISSA_BITS = 7,
  parameter int EXPONENT_BITS = 8,
  parameter int ACC_INT_BITS  = 16,
  parameter int ACC_FRAC_BITS = 16
) (
  input  logic [float_width(MANTISSA_BITS, EXPONENT_BITS)-1:0] float_i,
  output logic [ACC_INT_BITS+ACC_FRAC_BITS-1:0]                fixed_o,
  output logic                                                 ovf_o
);

  localparam int FW   = float_width(MANTISSA_BITS, EXPONENT_BITS);
  localparam int AW   = ACC_INT_BITS + ACC_FRAC_BITS;
  localparam int BIAS = exp_bias(EXPONENT_BITS);

  logic [EXPONENT_BITS-1:0] exp_f;
  logic [MANTISSA_BITS-1:0] mant_f;
  logic                     sign_unused;

  // Inputs are e^x, so the sign carries no information here.
  assign sign_unused = float_i[FW-1];
  assign exp_f       = float_i[FW-2 -: EXPONENT_BITS];
  assign mant_f      = float_i[MANTISSA_BITS-1:0];

  always_comb begin
    int            e;
    int            sh;
    logic [AW-1:0] v;
    fixed_o = '0;
    ovf_o   = 1'b0;
    e       = int'(exp_f) - BIAS;
    sh      = e - MANTISSA_BITS + ACC_FRAC_BITS;
    v       = AW'({1'b1, mant_f});
    if (exp_f == '0) begin
      fixed_o = '0;
    end else if ((&exp_f) || (e >= ACC_INT_BITS)) begin
      // Inf/NaN or a value beyond the integer range both pin to all-ones.
      fixed_o = '1;
      ovf_o   = 1'b1;
    end else if (sh >= 0) begin
      fixed_o = v << sh;
    end else begin
      fixed_o = v >> (-sh);
    end
  end

endmodule

// File: rtl/expu_accumulator.sv
// rtl/expu_accumulator.sv - per-packet saturating sum of e^x floats (softmax denominator)
module expu_accumulator
  import expu_pkg::*;
#(
  parameter int MANTISSA_BITS = 7,
  parameter int EXPONENT_BITS = 8,
  parameter int ACC_INT_BITS  = 16,
  parameter int ACC_FRAC_BITS = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clear_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic [MANTISSA_BITS+EXPONENT_BITS:0]     float_i,
  input  logic                                     last_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic [ACC_INT_BITS+ACC_FRAC_BITS-1:0]    sum_o,
  output logic [CNT_WIDTH-1:0]                     count_o,
  output logic                                     overflow_o
);

  localparam int AW = ACC_INT_BITS + ACC_FRAC_BITS;

  state_e          state_q, state_d;
  logic            beat_acc;
  logic [AW-1:0]   conv_fixed;
  logic            conv_ovf;

  logic            align_valid_q;
  logic [AW-1:0]   align_data_q;
  logic            align_ovf_q;
  logic            align_last_q;

  logic [AW-1:0]   acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic            ovf_q;
  logic [AW:0]     acc_sum;

  assign ready_o  = !rst_i && (state_q == S_ACC);
  assign beat_acc = valid_i && ready_o;

  expu_fp2fix #(
    .MANTISSA_BITS(MANTISSA_BITS),
    .EXPONENT_BITS(EXPONENT_BITS),
    .ACC_INT_BITS (ACC_INT_BITS),
    .ACC_FRAC_BITS(ACC_FRAC_BITS)
  ) u_fp2fix (
    .float_i(float_i),
    .fixed_o(conv_fixed),
    .ovf_o  (conv_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      align_valid_q <= 1'b0;
      align_data_q  <= '0;
      align_ovf_q   <= 1'b0;
      align_last_q  <= 1'b0;
    end else begin
      align_valid_q <= beat_acc;
      if (beat_acc) begin
        align_data_q <= conv_fixed;
        align_ovf_q  <= conv_ovf;
        align_last_q <= last_i;
      end
    end
  end

  assign acc_sum = {1'b0, acc_q} + {1'b0, align_data_q};

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if ((state_q == S_OUT) && ready_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (align_valid_q) begin
      acc_q <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
      ovf_q <= ovf_q | acc_sum[AW] | align_ovf_q;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // S_DRAIN holds until the last beat has landed in the accumulator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (beat_acc && last_i) state_d = S_DRAIN;
      S_DRAIN: if (!align_valid_q) state_d = S_OUT;
      S_OUT:   if (ready_i) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  logic align_last_unused;
  assign align_last_unused = align_last_q;

  assign valid_o    = (state_q == S_OUT);
  assign sum_o      = acc_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule
